// File: rtl/iq_fir_pkg.sv
// ============================================================================
// Module   : iq_fir_pkg
// Purpose  : Shared types, default coefficients and helpers for iq_fir_mac.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package iq_fir_pkg;

   localparam int DATA_W_DEF = 5;
   localparam int OUT_W_DEF  = 5;
   localparam int COEF_W_DEF = 8;
   localparam int TAPS_DEF   = 8;

   typedef logic signed [DATA_W_DEF-1:0] sample_t;
   typedef logic signed [OUT_W_DEF-1:0]  out_t;
   typedef logic signed [COEF_W_DEF-1:0] coef_t;
   typedef coef_t [TAPS_DEF-1:0]         coef_arr_t;

   // Index 0 (rightmost) multiplies the newest sample; sum is 128 for unity DC gain.
   localparam coef_arr_t H_DEFAULT = {8'sd3, 8'sd10, 8'sd22, 8'sd29,
                                      8'sd29, 8'sd22, 8'sd10, 8'sd3};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   function automatic int acc_width(input int dw, input int cw, input int taps);
      return dw + cw + $clog2(taps);
   endfunction

endpackage

`default_nettype wire

// File: rtl/iq_fir_round_sat.sv
// ============================================================================
// Module   : iq_fir_round_sat
// Purpose  : Round-half-up, shift by COEF_FRAC and reduce to OUT_W bits.
//            IQ_FIR_SAT_EN selects clamping; otherwise two's-complement wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iq_fir_round_sat
   import iq_fir_pkg::*;
#(
   parameter int ACC_W     = 16,
   parameter int OUT_W     = 5,
   parameter int COEF_FRAC = 7
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [OUT_W-1:0] rounded
);

   localparam int SW = ACC_W + 1;
   localparam logic signed [SW-1:0] HALF = SW'(2 ** (COEF_FRAC - 1));

   logic signed [SW-1:0] biased;
   logic signed [SW-1:0] shifted;

   // One guard bit keeps the rounding add from ever overflowing.
   assign biased  = {acc[ACC_W-1], acc} + HALF;
   assign shifted = biased >>> COEF_FRAC;

`ifdef IQ_FIR_SAT_EN
   localparam logic signed [SW-1:0] MAX_V = SW'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

   always_comb begin
      rounded = shifted[OUT_W-1:0];
      if (shifted > MAX_V) begin
         rounded = MAX_V[OUT_W-1:0];
      end else if (shifted < MIN_V) begin
         rounded = MIN_V[OUT_W-1:0];
      end
   end
`else
   assign rounded = shifted[OUT_W-1:0];
`endif

   logic unused_bits;
   assign unused_bits = ^shifted;

endmodule

`default_nettype wire

// File: rtl/iq_fir_mac.sv
// ============================================================================
// Module   : iq_fir_mac
// Purpose  : Time-multiplexed I/Q FIR low-pass, one multiplier per channel.
//            Output reduction mode selected by IQ_FIR_SAT_EN (see round_sat).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iq_fir_mac
   import iq_fir_pkg::*;
#(
   parameter int                      DATA_W    = 5,
   parameter int                      OUT_W     = 5,
   parameter int                      COEF_W    = 8,
   parameter int                      COEF_FRAC = 7,
   parameter int                      TAPS      = 8,
   parameter logic [TAPS*COEF_W-1:0]  COEFS     = H_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] data_in_i,
   input  logic signed [DATA_W-1:0] data_in_q,
   output logic                     pret,
   output logic                     out_valid,
   output logic signed [OUT_W-1:0]  data_out_i,
   output logic signed [OUT_W-1:0]  data_out_q
);

   localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
   localparam int K_W   = $clog2(TAPS);

   state_t                   state, state_nxt;
   logic [K_W-1:0]           k;
   logic signed [DATA_W-1:0] x_i [TAPS];
   logic signed [DATA_W-1:0] x_q [TAPS];
   logic signed [ACC_W-1:0]  acc_i, acc_q;
   logic signed [ACC_W-1:0]  acc_i_nxt, acc_q_nxt;
   logic signed [ACC_W-1:0]  xi_ext, xq_ext, h_ext;
   logic signed [COEF_W-1:0] h_k;
   logic signed [OUT_W-1:0]  rnd_i, rnd_q;
   logic                     accept;
   logic                     last_mac;

   assign pret     = (state != ST_MAC) && !reset;
   assign accept   = in_valid && pret;
   assign last_mac = (state == ST_MAC) && (k == K_W'(TAPS - 1));

   assign h_k    = COEFS[k*COEF_W +: COEF_W];
   assign h_ext  = {{(ACC_W-COEF_W){h_k[COEF_W-1]}}, h_k};
   assign xi_ext = {{(ACC_W-DATA_W){x_i[k][DATA_W-1]}}, x_i[k]};
   assign xq_ext = {{(ACC_W-DATA_W){x_q[k][DATA_W-1]}}, x_q[k]};

   assign acc_i_nxt = acc_i + xi_ext * h_ext;
   assign acc_q_nxt = acc_q + xq_ext * h_ext;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) state_nxt = ST_MAC;
         end
         ST_MAC: begin
            if (last_mac) state_nxt = ST_OUT;
         end
         ST_OUT: begin
            out_valid = 1'b1;
            state_nxt = accept ? ST_MAC : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are registered from the final partial sum so they are valid in OUT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         k          <= '0;
         acc_i      <= '0;
         acc_q      <= '0;
         data_out_i <= '0;
         data_out_q <= '0;
         for (int t = 0; t < TAPS; t++) begin
            x_i[t] <= '0;
            x_q[t] <= '0;
         end
      end else begin
         if (accept) begin
            for (int t = TAPS - 1; t > 0; t--) begin
               x_i[t] <= x_i[t-1];
               x_q[t] <= x_q[t-1];
            end
            x_i[0] <= data_in_i;
            x_q[0] <= data_in_q;
            acc_i  <= '0;
            acc_q  <= '0;
            k      <= '0;
         end else if (state == ST_MAC) begin
            acc_i <= acc_i_nxt;
            acc_q <= acc_q_nxt;
            k     <= k + 1'b1;
         end
         if (last_mac) begin
            data_out_i <= rnd_i;
            data_out_q <= rnd_q;
         end
      end
   end

   iq_fir_round_sat #(
      .ACC_W     (ACC_W),
      .OUT_W     (OUT_W),
      .COEF_FRAC (COEF_FRAC)
   ) u_round_i (
      .acc     (acc_i_nxt),
      .rounded (rnd_i)
   );

   iq_fir_round_sat #(
      .ACC_W     (ACC_W),
      .OUT_W     (OUT_W),
      .COEF_FRAC (COEF_FRAC)
   ) u_round_q (
      .acc     (acc_q_nxt),
      .rounded (rnd_q)
   );

endmodule

`default_nettype wire
